instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 252 +++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Packs instruction fields (opcode, rd, rs1, rs2, funct3, funct7) and a
//   full-width immediate into a 32-bit instruction word. The layout is chosen
//   from the opcode (U, UJ, S/SB, R, I) and the immediate bits overwrite the
//   common field positions where that layout places them. The packing is the
//   bit-exact inverse of the immediate generator used by the decoder.
//
//   Two-stage valid/ready pipeline:
//     stage 1 registers the accepted request,
//     stage 2 registers the encoded word and imm_err.
//   A stage advances when its downstream is empty or draining this cycle, so
//   simultaneous accept and drain moves everything with no bubble.
//
// Optional feature:
//   INSTR_ENC_RANGE_CHECK_EN  when defined, imm_err flags immediates that do
//                             not fit the selected layout (the word still
//                             carries the truncated encoding). When undefined
//                             imm_err is tied low and truncation is silent.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   in_valid   in   1   request present
//   in_ready   out  1   request can be accepted this cycle
//   opcode     in   7   instruction opcode
//   rd/rs1/rs2 in   5   register fields
//   funct3     in   3   function field
//   funct7     in   7   function field
//   imm        in   32  immediate value to pack
//   out_valid  out  1   encoded word available
//   out_ready  in   1   consumer accepts word this cycle
//   instr      out  32  encoded instruction
//   imm_err    out  1   immediate not representable (qualified by out_valid)
//   enc_count  out  16  number of delivered words, wraps silently
// ---------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        imm_err,
  output logic [15:0] enc_count
);

  localparam logic [6:0] OPC_U   = 7'b0110111;
  localparam logic [6:0] OPC_UJ  = 7'b1101111;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_SB  = 7'b1100111;
  localparam logic [6:0] OPC_R   = 7'b0110011;

  typedef enum logic [2:0] {
    LAYOUT_I,
    LAYOUT_S,
    LAYOUT_U,
    LAYOUT_UJ,
    LAYOUT_R
  } layout_e;

  // Stage 1: captured request
  logic        s1_valid_q,  s1_valid_d;
  logic [6:0]  s1_opcode_q, s1_opcode_d;
  logic [4:0]  s1_rd_q,     s1_rd_d;
  logic [4:0]  s1_rs1_q,    s1_rs1_d;
  logic [4:0]  s1_rs2_q,    s1_rs2_d;
  logic [2:0]  s1_funct3_q, s1_funct3_d;
  logic [6:0]  s1_funct7_q, s1_funct7_d;
  logic [31:0] s1_imm_q,    s1_imm_d;

  // Stage 2: encoded result
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q,     instr_d;
  logic        imm_err_q,   imm_err_d;

  logic [15:0] enc_count_q, enc_count_d;

  // Handshake
  logic accept;
  logic s2_load;
  logic deliver;

  // Encoder datapath (operates on stage-1 contents)
  layout_e     layout;
  logic [31:0] enc_word;
  logic        range_err;

  // Stage 2 takes the stage-1 word when it is empty or its word leaves now.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  // Stage 1 can refill in the same cycle it hands its word forward.
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  // -------------------------------------------------------------------------
  // Layout selection
  // -------------------------------------------------------------------------
  always_comb begin
    layout = LAYOUT_I;
    case (s1_opcode_q)
      OPC_U:         layout = LAYOUT_U;
      OPC_UJ:        layout = LAYOUT_UJ;
      OPC_S, OPC_SB: layout = LAYOUT_S;
      OPC_R:         layout = LAYOUT_R;
      default:       layout = LAYOUT_I;
    endcase
  end

  // -------------------------------------------------------------------------
  // Field packing: start from the common field map, then let the layout's
  // immediate bits overwrite their positions.
  // -------------------------------------------------------------------------
  always_comb begin
    enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
    case (layout)
      LAYOUT_I: begin
        enc_word[31:20] = s1_imm_q[11:0];
      end
      LAYOUT_S: begin
        // Branches share the store layout; the immediate is not half-word shifted.
        enc_word[31:25] = s1_imm_q[11:5];
        enc_word[11:7]  = s1_imm_q[4:0];
      end
      LAYOUT_U: begin
        enc_word[31:12] = s1_imm_q[31:12];
      end
      LAYOUT_UJ: begin
        enc_word[31]    = s1_imm_q[31];
        enc_word[30:21] = s1_imm_q[10:1];
        enc_word[20]    = s1_imm_q[0];
        enc_word[19]    = s1_imm_q[11];
        enc_word[18:12] = s1_imm_q[18:12];
      end
      default: begin
        // R layout carries no immediate bits.
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Immediate range check
  // -------------------------------------------------------------------------
`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits when every bit above the encoded sign position equals
  // that sign bit; U-type additionally requires the dropped low 12 bits be 0.
  always_comb begin
    range_err = 1'b0;
    case (layout)
      LAYOUT_I, LAYOUT_S: range_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
      LAYOUT_UJ:          range_err = !((&s1_imm_q[31:19]) || !(|s1_imm_q[31:19]));
      LAYOUT_U:           range_err = |s1_imm_q[11:0];
      default:            range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_opcode_d = s1_opcode_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_funct3_d = s1_funct3_q;
    s1_funct7_d = s1_funct7_q;
    s1_imm_d    = s1_imm_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    imm_err_d   = imm_err_q;
    enc_count_d = enc_count_q;

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_opcode_d = opcode;
      s1_rd_d     = rd;
      s1_rs1_d    = rs1;
      s1_rs2_d    = rs2;
      s1_funct3_d = funct3;
      s1_funct7_d = funct7;
      s1_imm_d    = imm;
    end else if (s2_load) begin
      s1_valid_d  = 1'b0;
    end

    // Output word holds while stalled; it is only replaced on a stage advance.
    if (s2_load) begin
      out_valid_d = 1'b1;
      instr_d     = enc_word;
      imm_err_d   = range_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (deliver) begin
      enc_count_d = enc_count_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      imm_err_q   <= 1'b0;
      enc_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s1_imm_q    <= s1_imm_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      imm_err_q   <= imm_err_d;
      enc_count_q <= enc_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign imm_err   = imm_err_q;
  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A cycle-stepping driver keeps a
// transaction-level reference (queue of expected words plus occupancy) and
// compares handshake, ordering, stall stability and the delivered-word count
// every cycle. Expected words come from a per-bit immediate placement table;
// in-range immediates are also decoded back and compared with the original.
// A table of hand-computed vectors, a random stream, a mid-flight reset and a
// counter wrap run complete the test.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC_ON = 1'b1;
`else
  localparam bit RC_ON = 1'b0;
`endif

  localparam int LAY_I  = 0;
  localparam int LAY_S  = 1;
  localparam int LAY_U  = 2;
  localparam int LAY_UJ = 3;
  localparam int LAY_R  = 4;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        req;
    logic [31:0] exp_instr;
    logic        exp_err_rc;  // imm_err expected when range checking is built in
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    int          lay;
    bit          chk_rt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;
  logic [15:0] enc_count;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .imm_err   (imm_err),
    .enc_count (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the test is sized well below this bound.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   checks;
  int   failures;
  exp_t exp_q[$];
  int   delivered;
  bit   acc_last;
  bit   prev_stall;
  logic [31:0] prev_instr;
  logic        prev_err;
  logic [31:0] last_instr;
  logic        last_err;
  bit          last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int layout_of(input logic [6:0] op);
    case (op)
      7'b0110111:             return LAY_U;
      7'b1101111:             return LAY_UJ;
      7'b0100011, 7'b1100111: return LAY_S;
      7'b0110011:             return LAY_R;
      default:                return LAY_I;
    endcase
  endfunction

  // Which immediate bit lands at instruction bit p (-1 = common field).
  function automatic int imm_src(input int lay, input int p);
    case (lay)
      LAY_I:  return (p >= 20) ? p - 20 : -1;
      LAY_S: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
        return -1;
      end
      LAY_U:  return (p >= 12) ? p : -1;
      LAY_UJ: begin
        if (p == 31) return 31;
        if (p >= 21) return p - 20;
        if (p == 20) return 0;
        if (p == 19) return 11;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic bit out_of_range(input int lay, input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    case (lay)
      LAY_I, LAY_S: return (s < -2048) || (s > 2047);
      LAY_UJ:       return (s < -524288) || (s > 524287);
      LAY_U:        return (v % 32'd4096) != 32'd0;
      default:      return 1'b0;
    endcase
  endfunction

  // Immediate generator: recovers the immediate from an encoded word.
  function automatic logic [31:0] decode(input logic [31:0] w, input int lay);
    case (lay)
      LAY_I:  return {{20{w[31]}}, w[31:20]};
      LAY_S:  return {{20{w[31]}}, w[31:25], w[11:7]};
      LAY_U:  return {w[31:12], 12'h000};
      LAY_UJ: return {{12{w[31]}}, w[31], w[18:12], w[19], w[30:21], w[20]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t        e;
    int          lay;
    int          s;
    logic [31:0] w;
    lay = layout_of(r.op);
    w   = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
    for (int p = 0; p < 32; p++) begin
      s = imm_src(lay, p);
      if (s >= 0) w[p] = r.imm[s];
    end
    e.instr  = w;
    e.err    = RC_ON && out_of_range(lay, r.imm);
    e.imm    = r.imm;
    e.lay    = lay;
    e.chk_rt = (lay != LAY_R) && !out_of_range(lay, r.imm);
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t        r;
    logic [31:0] tmp;
    case ($urandom_range(0, 7))
      0:       r.op = 7'h37;
      1:       r.op = 7'h6F;
      2:       r.op = 7'h23;
      3:       r.op = 7'h67;
      4:       r.op = 7'h33;
      5:       r.op = 7'h13;
      6:       r.op = 7'h03;
      default: r.op = 7'($urandom());
    endcase
    r.rd  = 5'($urandom());
    r.rs1 = 5'($urandom());
    r.rs2 = 5'($urandom());
    r.f3  = 3'($urandom());
    r.f7  = 7'($urandom());
    tmp   = $urandom();
    case ($urandom_range(0, 3))
      0:       r.imm = tmp;
      1:       r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       r.imm = 32'($urandom_range(0, 1048575)) - 32'd524288;
      default: r.imm = tmp & 32'hFFFFF000;
    endcase
    return r;
  endfunction

  // ---------------- per-cycle driver and checker ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit iv, input req_t r, input bit ordy);
    bit   exp_rdy;
    bit   exp_ov;
    bit   acc;
    exp_t e;
    in_valid  = iv;
    opcode    = r.op;
    rd        = r.rd;
    rs1       = r.rs1;
    rs2       = r.rs2;
    funct3    = r.f3;
    funct7    = r.f7;
    imm       = r.imm;
    out_ready = ordy;
    #1;
    // Two words in flight means both stages are full.
    exp_rdy = !(exp_q.size() == 2 && !ordy);
    // A lone word accepted at the last edge is still in the first stage.
    exp_ov  = (exp_q.size() == 2) || (exp_q.size() == 1 && !acc_last);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("enc_count", 32'(enc_count), 32'(delivered) & 32'h0000FFFF);
    if (prev_stall) begin
      chk("stall_instr", instr, prev_instr);
      chk("stall_imm_err", 32'(imm_err), 32'(prev_err));
    end
    if (exp_ov && ordy) begin
      e = exp_q.pop_front();
      chk("instr", instr, e.instr);
      chk("imm_err", 32'(imm_err), 32'(e.err));
      if (e.chk_rt) chk("roundtrip", decode(instr, e.lay), e.imm);
      last_instr = instr;
      last_err   = imm_err;
      last_valid = 1'b1;
      delivered++;
    end
    acc = iv && exp_rdy;
    if (acc) exp_q.push_back(model(r));
    acc_last   = acc;
    prev_stall = exp_ov && !ordy;
    prev_instr = instr;
    prev_err   = imm_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd_v,
                              input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm_v, input logic [31:0] ei,
                              input logic ee);
    vec_t v;
    v.req.op  = op;
    v.req.rd  = rd_v;
    v.req.rs1 = rs1_v;
    v.req.rs2 = rs2_v;
    v.req.f3  = f3;
    v.req.f7  = f7;
    v.req.imm = imm_v;
    v.exp_instr  = ei;
    v.exp_err_rc = ee;
    return v;
  endfunction

  vec_t vecs[13];
  req_t idle_r;
  int   cyc;
  int   ov_cnt;

  initial begin
    checks     = 0;
    failures   = 0;
    delivered  = 0;
    acc_last   = 1'b0;
    prev_stall = 1'b0;
    prev_instr = '0;
    prev_err   = 1'b0;
    last_instr = '0;
    last_err   = 1'b0;
    last_valid = 1'b0;
    idle_r     = '{op: 7'h0, rd: 5'h0, rs1: 5'h0, rs2: 5'h0, f3: 3'h0, f7: 7'h0, imm: 32'h0};

    //            op     rd     rs1    rs2    f3    f7     imm           instr         err(rc)
    vecs[0]  = mk(7'h13, 5'd5,  5'd6,  5'h1F, 3'd0, 7'h55, 32'hFFFFFFFF, 32'hFFF30293, 1'b0);
    vecs[1]  = mk(7'h23, 5'h1F, 5'd2,  5'd1,  3'd2, 7'h11, 32'h00000804, 32'h80112223, 1'b1);
    vecs[2]  = mk(7'h6F, 5'd1,  5'h1F, 5'h1F, 3'd7, 7'h7F, 32'h00040ABC, 32'h2BCC00EF, 1'b0);
    vecs[3]  = mk(7'h33, 5'd3,  5'd4,  5'd5,  3'd6, 7'h20, 32'hDEADBEEF, 32'h405261B3, 1'b0);
    vecs[4]  = mk(7'h37, 5'd10, 5'd5,  5'd9,  3'd3, 7'h01, 32'h12345000, 32'h12345537, 1'b0);
    vecs[5]  = mk(7'h37, 5'd10, 5'd5,  5'd9,  3'd3, 7'h01, 32'h12345678, 32'h12345537, 1'b1);
    vecs[6]  = mk(7'h13, 5'd0,  5'd0,  5'd3,  3'd0, 7'h01, 32'h000007FF, 32'h7FF00013, 1'b0);
    vecs[7]  = mk(7'h13, 5'd0,  5'd0,  5'd3,  3'd0, 7'h01, 32'h00000800, 32'h80000013, 1'b1);
    vecs[8]  = mk(7'h13, 5'd0,  5'd0,  5'd3,  3'd0, 7'h01, 32'hFFFFF800, 32'h80000013, 1'b0);
    vecs[9]  = mk(7'h67, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFFFFFE, 32'hFE208F67, 1'b0);
    vecs[10] = mk(7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00080000, 32'h0000006F, 1'b1);
    vecs[11] = mk(7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFF80000, 32'h8000006F, 1'b0);
    vecs[12] = mk(7'h03, 5'd2,  5'd3,  5'd0,  3'd2, 7'h00, 32'h00000010, 32'h0101A103, 1'b0);

    // ---------------- reset state ----------------
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_imm_err", 32'(imm_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 13; i++) begin
      last_valid = 1'b0;
      step(1'b1, vecs[i].req, 1'b1);
      step(1'b0, idle_r, 1'b1);   // word in stage 1, out_valid must stay low
      step(1'b0, idle_r, 1'b1);   // word delivered here
      chk("vec_delivered", 32'(last_valid), 32'd1);
      chk("vec_instr", last_instr, vecs[i].exp_instr);
      chk("vec_imm_err", 32'(last_err), RC_ON ? 32'(vecs[i].exp_err_rc) : 32'd0);
      $display("vec %0d op=%02h imm=%08h instr=%08h imm_err=%0b",
               i, vecs[i].req.op, vecs[i].req.imm, last_instr, last_err);
    end

    // ---------------- random stream with random back-pressure ----------------
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_req(), $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(1'b0, idle_r, 1'b1);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    $display("random stream delivered=%0d enc_count=%0d", delivered, enc_count);

    // ---------------- reset with both stages full ----------------
    step(1'b1, rand_req(), 1'b0);
    step(1'b1, rand_req(), 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_enc_count", 32'(enc_count), 32'(delivered) & 32'h0000FFFF);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", instr, 32'd0);
    chk("async_rst_imm_err", 32'(imm_err), 32'd0);
    chk("async_rst_enc_count", 32'(enc_count), 32'd0);
    exp_q.delete();
    delivered  = 0;
    acc_last   = 1'b0;
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b0, idle_r, 1'b1);
    $display("mid-flight reset: in-flight words discarded");

    // ---------------- sustained throughput and counter wrap ----------------
    cyc    = 0;
    ov_cnt = 0;
    while (delivered < 65535 && cyc < 70000) begin
      if (out_valid === 1'b1) ov_cnt++;
      step(1'b1, rand_req(), 1'b1);
      cyc++;
    end
    chk("wrap_reached_ffff", 32'(delivered), 32'd65535);
    chk("throughput", 32'(ov_cnt), 32'(cyc - 2));
    chk("enc_count_ffff", 32'(enc_count), 32'h0000FFFF);
    step(1'b0, idle_r, 1'b1);
    chk("enc_count_wrap", 32'(enc_count), 32'd0);
    $display("wrap run cycles=%0d words=%0d enc_count=%04h", cyc + 1, delivered, enc_count);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(1'b0, idle_r, 1'b1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
